// File: rtl/seq_pattern_tx.sv
// ============================================================================
//  Module   : seq_pattern_tx
//  Brief    : Serial MSB-first pattern transmitter with repetitions, idle gaps
//             and per-frame last flag. Optional macro SEQ_TX_PARITY_EN appends
//             an even-parity bit to each repetition.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_pattern_tx #(
   parameter int PAT_W      = 4,
   parameter int CNT_W      = 4,
   parameter int GAP        = 0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] repeat_i,
   output logic             x_o,
   output logic             valid_o,
   output logic             last_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int             IW       = $clog2(PAT_W);
   localparam int             GW       = $clog2(GAP + 2);
   localparam logic [IW-1:0]  IDX_MSB  = IW'(PAT_W - 1);
   localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
   localparam bit             HAS_GAP  = (GAP > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP_S = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [PAT_W-1:0]   pat_q,   pat_d;
   logic [CNT_W-1:0]   rep_q,   rep_d;
   logic [IW-1:0]      idx_q,   idx_d;
   logic [GW-1:0]      gap_q,   gap_d;
`ifdef SEQ_TX_PARITY_EN
   logic               par_q,   par_d;
`endif
   logic               x_q,     x_d;
   logic               valid_q, valid_d;
   logic               last_q,  last_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic               frame_end;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pat_q   <= '0;
         rep_q   <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
`ifdef SEQ_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
         x_q     <= IDLE_LEVEL;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rep_q   <= rep_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
`ifdef SEQ_TX_PARITY_EN
         par_q   <= par_d;
`endif
         x_q     <= x_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Outputs are computed from the current state and registered, which gives
   // the one-cycle latency between start acceptance and the first bit.
   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      rep_d     = rep_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
`ifdef SEQ_TX_PARITY_EN
      par_d     = par_q;
`endif
      x_d       = IDLE_LEVEL;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      frame_end = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (repeat_i != '0) begin
                  pat_d   = pattern_i;
                  rep_d   = repeat_i;
                  idx_d   = IDX_MSB;
`ifdef SEQ_TX_PARITY_EN
                  par_d   = 1'b0;
`endif
                  state_d = SHIFT;
               end else begin
                  state_d = DONE;
               end
            end
         end

         SHIFT: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
            if (par_q) begin
               x_d       = ^pat_q;
               last_d    = 1'b1;
               frame_end = 1'b1;
            end else begin
               x_d = pat_q[idx_q];
               if (idx_q == '0) begin
                  par_d = 1'b1;
               end else begin
                  idx_d = idx_q - 1'b1;
               end
            end
`else
            x_d = pat_q[idx_q];
            if (idx_q == '0) begin
               last_d    = 1'b1;
               frame_end = 1'b1;
            end else begin
               idx_d = idx_q - 1'b1;
            end
`endif
            if (frame_end) begin
`ifdef SEQ_TX_PARITY_EN
               par_d = 1'b0;
`endif
               idx_d = IDX_MSB;
               // Saturating decrement: the counter never wraps below zero.
               rep_d = (rep_q != '0) ? (rep_q - 1'b1) : '0;
               if (rep_q <= CNT_W'(1)) begin
                  state_d = DONE;
               end else if (HAS_GAP) begin
                  gap_d   = GAP_LAST;
                  state_d = GAP_S;
               end
            end
         end

         GAP_S: begin
            busy_d = 1'b1;
            if (gap_q == '0) begin
               state_d = SHIFT;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign x_o     = x_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Brief    : Directed self-checking bench for seq_pattern_tx (GAP=0 and GAP=2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_tx;

   localparam int PW = 4;
`ifdef SEQ_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F = PW + PAR;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start0 = 1'b0;
   logic          start2 = 1'b0;
   logic [PW-1:0] pattern = '0;
   logic [3:0]    rep = '0;
   logic x0, v0, l0, b0, d0;
   logic x2, v2, l2, b2, d2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seq_pattern_tx #(.PAT_W(PW), .CNT_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
      .clk_i(clk), .reset_i(reset), .start_i(start0), .pattern_i(pattern),
      .repeat_i(rep), .x_o(x0), .valid_o(v0), .last_o(l0), .busy_o(b0), .done_o(d0));

   seq_pattern_tx #(.PAT_W(PW), .CNT_W(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut2 (
      .clk_i(clk), .reset_i(reset), .start_i(start2), .pattern_i(pattern),
      .repeat_i(rep), .x_o(x2), .valid_o(v2), .last_o(l2), .busy_o(b2), .done_o(d2));

   // Expected {x,valid,last,busy,done} j cycles after the start-accept edge.
   function automatic logic [4:0] exp_at(input logic [PW-1:0] p, input int r,
                                         input int gap, input int j);
      int t, pos, off;
      logic [4:0] e;
      e = 5'b0;
      t = (r == 0) ? 0 : (r * F + (r - 1) * gap);
      if (j >= 1 && j <= t) begin
         pos = j - 1;
         off = pos % (F + gap);
         if (off < F) begin
            e[4] = (off < PW) ? p[PW-1-off] : ^p;
            e[3] = 1'b1;
            e[2] = (off == F - 1);
         end
         e[1] = 1'b1;
      end else if (j == t + 1) begin
         e[0] = 1'b1;
      end
      return e;
   endfunction

   // Starts a transfer on one instance and checks every cycle until idle.
   // poke_at >= 0 pulses a second start (with a zero pattern) at that cycle.
   task automatic run_check(input bit sel, input logic [PW-1:0] p, input int r,
                            input int gap, input string name, input int poke_at);
      logic [4:0] obs, e;
      int t;
      t = (r == 0) ? 0 : (r * F + (r - 1) * gap);
      @(negedge clk);
      pattern = p;
      rep     = 4'(r);
      if (sel) start2 = 1'b1; else start0 = 1'b1;
      @(posedge clk);
      #1;
      start0  = 1'b0;
      start2  = 1'b0;
      pattern = ~p;
      rep     = 4'(r + 1);
      for (int j = 0; j <= t + 3; j++) begin
         @(negedge clk);
         obs = sel ? {x2, v2, l2, b2, d2} : {x0, v0, l0, b0, d0};
         e   = exp_at(p, r, gap, j);
         vectors++;
         if (obs !== e) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got {x,v,l,b,d}=%b expected %b", name, j, obs, e);
         end
         if (j == poke_at) begin
            pattern = '0;
            rep     = 4'd5;
            if (sel) start2 = 1'b1; else start0 = 1'b1;
         end else if (j == poke_at + 1) begin
            start0 = 1'b0;
            start2 = 1'b0;
         end
      end
   endtask

   task automatic check_idle(input string name, input int n);
      logic [9:0] obs;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         obs = {x0, v0, l0, b0, d0, x2, v2, l2, b2, d2};
         vectors++;
         if (obs !== 10'b0) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got %b expected %b", name, j, obs, 10'b0);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      check_idle("reset_hold", 1);
      reset = 1'b0;
      check_idle("after_reset", 2);
   endtask

   task automatic test_single_frame();
      run_check(1'b0, 4'b1011, 1, 0, "single_1011", -1);
      run_check(1'b0, 4'b0100, 1, 0, "single_0100", -1);
   endtask

   task automatic test_back_to_back();
      run_check(1'b0, 4'b0110, 3, 0, "b2b_0110_r3", -1);
      run_check(1'b0, 4'b1001, 15, 0, "b2b_1001_r15", -1);
   endtask

   task automatic test_repeat_gap();
      run_check(1'b1, 4'b1010, 3, 2, "gap_1010_r3", -1);
      run_check(1'b1, 4'b1100, 1, 2, "gap_1100_r1", -1);
   endtask

   task automatic test_zero_repeat();
      run_check(1'b0, 4'b1111, 0, 0, "zero_rep", -1);
      run_check(1'b1, 4'b1111, 0, 2, "zero_rep_gap", -1);
   endtask

   task automatic test_start_while_busy();
      run_check(1'b0, 4'b1101, 1, 0, "busy_start", 1);
      run_check(1'b1, 4'b0111, 2, 2, "busy_start_gap", 5);
   endtask

   task automatic test_reset_mid_frame();
      logic [4:0] obs;
      @(negedge clk);
      pattern = 4'b1111;
      rep     = 4'd2;
      start0  = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({x0, v0, b0} !== 3'b111) begin
         miscompares++;
         $display("FAIL mid_frame_bit2: got {x,v,b}=%b expected %b", {x0, v0, b0}, 3'b111);
      end
      #2;
      reset = 1'b1;
      #1;
      obs = {x0, v0, l0, b0, d0};
      vectors++;
      if (obs !== 5'b0) begin
         miscompares++;
         $display("FAIL async_reset: got %b expected %b", obs, 5'b0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle("no_done_after_reset", 6);
      run_check(1'b0, 4'b1111, 1, 0, "after_reset_frame", -1);
   endtask

   initial begin
      fork
         begin
            #200000;
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
         end
      join_none
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_repeat_gap();
      test_zero_repeat();
      test_start_while_busy();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that drives a single-bit stream for sequence-detector blocks such as the Mealy detectors in this design. It takes a PAT_W-bit pattern and a repetition count, then shifts the pattern out MSB-first, one bit per clock. Optional idle gaps separate repetitions. A `last` flag marks each cycle where a matching detector is expected to assert its output.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of the repetition-count input
GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back)
IDLE_LEVEL, 0, value driven on x when no bit is valid

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  pattern to send, MSB first; latched on accepted start
repeat  input  CNT_W  number of repetitions; latched on accepted start
x  output  1  serial data out
valid  output  1  high when x carries a pattern (or parity) bit
last  output  1  high on the final bit of each repetition
busy  output  1  high from the cycle after start acceptance until the final bit (inclusive)
done  output  1  single-cycle pulse after the final repetition completes

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high. While reset is high: state=IDLE, counters cleared, x=IDLE_LEVEL, valid=0, last=0, busy=0, done=0.
- All outputs are registered.
- States: IDLE, SHIFT, GAP_S, DONE.
- IDLE:
  - outputs idle: x=IDLE_LEVEL, valid=0, last=0, busy=0, done=0.
  - start=1 with repeat!=0: latch pattern and repeat, go to SHIFT. Bit MSB appears on x in the next cycle (latency 1).
  - start=1 with repeat==0: go to DONE directly. No valid bits are sent.
- SHIFT:
  - each cycle, x=current bit, valid=1, busy=1. Bit index counts PAT_W-1 down to 0.
  - last=1 when index==0.
  - After bit 0: decrement the remaining-repeat counter.
    - counter now 0: go to DONE.
    - otherwise, GAP>0: go to GAP_S.
    - otherwise (GAP==0): reload index and send the next MSB in the following cycle.
- GAP_S:
  - x=IDLE_LEVEL, valid=0, last=0, busy=1, for exactly GAP cycles, then return to SHIFT at MSB.
- DONE:
  - one cycle with done=1, busy=0, valid=0, x=IDLE_LEVEL; then go to IDLE.
- Total cycles from start-accept edge to done: 1 + R*PAT_W + (R-1)*GAP, where R=repeat.
- Latching: pattern and repeat are latched once. Input changes during a transfer have no effect.
- start is ignored in SHIFT, GAP_S and DONE. There is no queuing.
- Counter widths: remaining-repeat counter is CNT_W bits; bit index is $clog2(PAT_W) bits. No wrap-around is permitted; the counter stops at 0.
- reset asserted mid-transfer: outputs return to reset values immediately (asynchronously). The partial frame is abandoned and no done pulse is issued.

Optional Feature:
Macro SEQ_TX_PARITY_EN.
- Defined: each repetition is followed by one even-parity bit, x = XOR of the latched pattern, with valid=1. last moves from bit 0 to the parity bit. Each frame is PAT_W+1 cycles, and the total latency formula uses PAT_W+1 in place of PAT_W.
- Undefined: no parity bit is sent; behaviour is exactly as described above.

Test Plan:
- Single frame: PAT_W=4, pattern=4'b1011, repeat=1, start pulsed at edge k -> x=1,0,1,1 on cycles k+1..k+4 with valid=1; last=1 only at k+4; done=1 at k+5; busy high k+1..k+4.
- Repeats with gap: pattern=4'b1010, repeat=3, GAP=2 -> three 1,0,1,0 frames, each separated by 2 cycles of valid=0 and x=0; last at k+4, k+10, k+16; done at k+17.
- Zero repeat: repeat=0, start at k -> done=1 at k+1; valid, last and busy stay 0 throughout.
- Start while busy and input changes: second start at k+2 with pattern=4'b0000 during a 4'b1101 frame -> frame still 1,1,0,1; exactly one done pulse at k+5.
- Reset mid-frame: reset asserted asynchronously during bit 2 of 4'b1111 -> x=IDLE_LEVEL, valid=0, busy=0 immediately; no done pulse; a new start after reset release sends a full frame.
- Parity build (SEQ_TX_PARITY_EN): pattern=4'b1011, repeat=1 -> x=1,0,1,1,1 on k+1..k+5; last at k+5; done at k+6.
